// File: rtl/noc_node_ni.sv
// noc_node_ni: node-side NoC interface, TX packetiser + per-VC RX FIFOs.
// Optional RX destination check enabled by NOC_NI_DEST_CHECK_EN.
`ifndef NOC_NODE_WIDTH
`define NOC_NODE_WIDTH 2
`endif

module noc_node_ni #(
  parameter int DATA_W   = 16,
  parameter int NODE_W   = `NOC_NODE_WIDTH,
  parameter int FLIT_W   = 1 + 1 + NODE_W + 1 + DATA_W,
  parameter int RX_DEPTH = 4,
  parameter int RX_SKID  = 1
) (
  input  logic              clk,
  input  logic              res,
  output logic [FLIT_W-1:0] noc_put_flit,
  output logic              noc_en_put,
  output logic              noc_en_get_non_full_VCs,
  input  logic [1:0]        noc_get_non_full_VCs,
  output logic              noc_en_get,
  input  logic [FLIT_W-1:0] noc_get_flit,
  output logic [1:0]        noc_put_non_full_VCs,
  output logic              noc_en_put_non_full_VCs,
  input  logic [NODE_W-1:0] noc_this_id,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [NODE_W-1:0] tx_dest,
  input  logic              tx_last,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_last,
  output logic              rx_vc,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_overflow,
  output logic              err_dest
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + DATA_W;
  localparam logic [CW-1:0] L_DEPTH = CW'(RX_DEPTH);
  localparam logic [CW-1:0] L_SKID  = CW'(RX_SKID);

  typedef enum logic {S_IDLE, S_LOCKED} tx_state_e;

  logic r_en;

  always_ff @(posedge clk) begin
    if (res) r_en <= 1'b0;
    else     r_en <= 1'b1;
  end

  assign noc_en_get              = r_en;
  assign noc_en_get_non_full_VCs = r_en;
  assign noc_en_put_non_full_VCs = r_en;

  tx_state_e         r_tx_state;
  tx_state_e         w_tx_next;
  logic [NODE_W-1:0] r_dest;
  logic              r_vc;
  logic [NODE_W-1:0] w_tx_dest;
  logic              w_tx_vc;
  logic              w_tx_ready;
  logic              w_tx_fire;

  always_comb begin
    w_tx_next  = r_tx_state;
    w_tx_vc    = r_vc;
    w_tx_dest  = r_dest;
    w_tx_ready = 1'b0;
    unique case (r_tx_state)
      S_IDLE: begin
        // lowest VC with space wins
        w_tx_vc    = ~noc_get_non_full_VCs[0];
        w_tx_dest  = tx_dest;
        w_tx_ready = r_en & (|noc_get_non_full_VCs);
        if (tx_valid && w_tx_ready && !tx_last)
          w_tx_next = S_LOCKED;
      end
      S_LOCKED: begin
        w_tx_ready = r_en & noc_get_non_full_VCs[r_vc];
        if (tx_valid && w_tx_ready && tx_last)
          w_tx_next = S_IDLE;
      end
      default: ;
    endcase
  end

  assign w_tx_fire  = tx_valid & w_tx_ready;
  assign tx_ready   = w_tx_ready;
  assign noc_en_put = w_tx_fire;
  assign noc_put_flit = w_tx_fire ?
    {1'b1, tx_last, w_tx_dest, w_tx_vc, tx_data} :
    {FLIT_W{1'b0}};

  always_ff @(posedge clk) begin
    if (res) begin
      r_tx_state <= S_IDLE;
      r_dest     <= '0;
      r_vc       <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      if (r_tx_state == S_IDLE && w_tx_fire && !tx_last) begin
        r_dest <= tx_dest;
        r_vc   <= w_tx_vc;
      end
    end
  end

  logic              w_in_valid;
  logic              w_in_vc;
  logic [NODE_W-1:0] w_in_dest;
  logic [EW-1:0]     w_in_entry;
  logic              w_dest_ok;

  assign w_in_valid = r_en & noc_get_flit[FLIT_W-1];
  assign w_in_vc    = noc_get_flit[DATA_W];
  assign w_in_dest  = noc_get_flit[DATA_W+NODE_W:DATA_W+1];
  assign w_in_entry = {noc_get_flit[DATA_W+NODE_W+1],
                       noc_get_flit[DATA_W-1:0]};

`ifdef NOC_NI_DEST_CHECK_EN
  logic r_err_dest;
  assign w_dest_ok = (w_in_dest == noc_this_id);
  always_ff @(posedge clk) begin
    if (res)                           r_err_dest <= 1'b0;
    else if (w_in_valid && !w_dest_ok) r_err_dest <= 1'b1;
  end
  assign err_dest = r_err_dest;
`else
  logic w_unused;
  assign w_unused  = ^{noc_this_id, w_in_dest};
  assign w_dest_ok = 1'b1;
  assign err_dest  = 1'b0;
`endif

  logic [EW-1:0]         r_mem [2][RX_DEPTH];
  logic [1:0][PW-1:0]    r_wp;
  logic [1:0][PW-1:0]    r_rp;
  logic [1:0][CW-1:0]    r_cnt;
  logic [1:0][CW-1:0]    w_cnt_nxt;
  logic [1:0]            w_full;
  logic [1:0]            w_empty;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            r_nf;
  logic                  w_ovf;
  logic                  r_ovf;
  logic                  r_lock;
  logic                  r_lock_vc;
  logic                  r_rr;
  logic                  w_sel;
  logic [EW-1:0]         w_head;

  // RR pointer only matters when no packet holds the output
  assign w_sel = r_lock ? r_lock_vc :
                 (w_empty[r_rr] ? ~r_rr : r_rr);
  assign w_head   = r_mem[w_sel][r_rp[w_sel]];
  assign rx_valid = ~w_empty[w_sel];
  assign rx_vc    = w_sel;
  assign rx_last  = w_head[DATA_W];
  assign rx_data  = w_head[DATA_W-1:0];

  always_comb begin
    w_full    = '0;
    w_empty   = '0;
    w_push    = '0;
    w_pop     = '0;
    w_cnt_nxt = '0;
    for (int v = 0; v < 2; v++) begin
      w_full[v]  = (r_cnt[v] == L_DEPTH);
      w_empty[v] = (r_cnt[v] == '0);
      w_pop[v]   = rx_valid & rx_ready & (w_sel == 1'(v));
      // pop-before-push lets a full FIFO accept when drained
      w_push[v]  = w_in_valid & w_dest_ok & (w_in_vc == 1'(v)) &
                   (~w_full[v] | w_pop[v]);
      w_cnt_nxt[v] = r_cnt[v] + CW'(w_push[v]) - CW'(w_pop[v]);
    end
    w_ovf = w_in_valid & w_dest_ok & w_full[w_in_vc] & ~w_pop[w_in_vc];
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++)
      if (w_push[v]) r_mem[v][r_wp[v]] <= w_in_entry;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_nf   <= '0;
      r_ovf  <= 1'b0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (w_push[v]) r_wp[v] <= r_wp[v] + PW'(1);
        if (w_pop[v])  r_rp[v] <= r_rp[v] + PW'(1);
        r_cnt[v] <= w_cnt_nxt[v];
        r_nf[v]  <= (L_DEPTH - w_cnt_nxt[v]) > L_SKID;
      end
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign noc_put_non_full_VCs = r_nf;
  assign rx_overflow          = r_ovf;

  always_ff @(posedge clk) begin
    if (res) begin
      r_lock    <= 1'b0;
      r_lock_vc <= 1'b0;
      r_rr      <= 1'b0;
    end else if (rx_valid && rx_ready && rx_last) begin
      r_lock <= 1'b0;
      r_rr   <= ~w_sel;
    end else if (rx_valid) begin
      r_lock    <= 1'b1;
      r_lock_vc <= w_sel;
    end
  end

endmodule

// File: tb/tb_noc_node_ni.sv
// tb_noc_node_ni: scoreboard bench for noc_node_ni TX/RX paths.
// Dest-check scenario adapts to NOC_NI_DEST_CHECK_EN.
module tb_noc_node_ni;

  localparam int FW = 21;

  logic          clk = 1'b0;
  logic          res;
  logic [FW-1:0] noc_put_flit;
  logic          noc_en_put;
  logic          noc_en_get_non_full_VCs;
  logic [1:0]    noc_get_non_full_VCs;
  logic          noc_en_get;
  logic [FW-1:0] noc_get_flit;
  logic [1:0]    noc_put_non_full_VCs;
  logic          noc_en_put_non_full_VCs;
  logic [1:0]    noc_this_id;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    tx_dest;
  logic          tx_last;
  logic [15:0]   tx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_last;
  logic          rx_vc;
  logic [15:0]   rx_data;
  logic          rx_overflow;
  logic          err_dest;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] tx_q[$];
  logic [17:0]   rx_q[$];

  always #5 clk = ~clk;

  noc_node_ni dut (
    .clk                     (clk),
    .res                     (res),
    .noc_put_flit            (noc_put_flit),
    .noc_en_put              (noc_en_put),
    .noc_en_get_non_full_VCs (noc_en_get_non_full_VCs),
    .noc_get_non_full_VCs    (noc_get_non_full_VCs),
    .noc_en_get              (noc_en_get),
    .noc_get_flit            (noc_get_flit),
    .noc_put_non_full_VCs    (noc_put_non_full_VCs),
    .noc_en_put_non_full_VCs (noc_en_put_non_full_VCs),
    .noc_this_id             (noc_this_id),
    .tx_valid                (tx_valid),
    .tx_ready                (tx_ready),
    .tx_dest                 (tx_dest),
    .tx_last                 (tx_last),
    .tx_data                 (tx_data),
    .rx_valid                (rx_valid),
    .rx_ready                (rx_ready),
    .rx_last                 (rx_last),
    .rx_vc                   (rx_vc),
    .rx_data                 (rx_data),
    .rx_overflow             (rx_overflow),
    .err_dest                (err_dest)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    tx_valid = 1'b1;
    noc_get_non_full_VCs = 2'b11;
    tick();
    tick();
    checks++;
    if ({noc_en_get, noc_en_get_non_full_VCs, noc_en_put_non_full_VCs,
         noc_en_put} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_en: got %b expected 0000",
               {noc_en_get, noc_en_get_non_full_VCs,
                noc_en_put_non_full_VCs, noc_en_put});
    end
    checks++;
    if ({noc_put_non_full_VCs, tx_ready, rx_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_out: nf/txr/rxv got %b expected 0000",
               {noc_put_non_full_VCs, tx_ready, rx_valid});
    end
    checks++;
    if ({rx_overflow, err_dest} !== 2'b00) begin
      errors++;
      $display("FAIL reset_sticky: got %b expected 00",
               {rx_overflow, err_dest});
    end
    tx_valid = 1'b0;
    res = 1'b0;
    tick();
    checks++;
    if ({noc_en_get, noc_en_get_non_full_VCs, noc_en_put_non_full_VCs,
         noc_put_non_full_VCs} !== 5'b11111) begin
      errors++;
      $display("FAIL post_reset_en: got %b expected 11111",
               {noc_en_get, noc_en_get_non_full_VCs,
                noc_en_put_non_full_VCs, noc_put_non_full_VCs});
    end
    tick();
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rx_valid: got %b expected 0", rx_valid);
    end
  endtask

  task automatic test_tx_packet();
    logic [FW-1:0] exp;
    noc_get_non_full_VCs = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_dest  = (i == 0) ? 2'd3 : 2'd0;
      tx_last  = (i == 2);
      tx_data  = 16'(i + 1);
      tx_q.push_back({1'b1, tx_last, 2'd3, 1'b0, tx_data});
      #1;
      exp = tx_q.pop_front();
      checks++;
      if (noc_en_put !== 1'b1 || noc_put_flit !== exp) begin
        errors++;
        $display("FAIL tx_word%0d: got en=%b flit=%h expected en=1 flit=%h",
                 i, noc_en_put, noc_put_flit, exp);
      end
      tick();
      if (i == 0) begin
        noc_get_non_full_VCs = 2'b10;
        tx_data = 16'h0002;
        for (int s = 0; s < 2; s++) begin
          #1;
          checks++;
          if ({tx_ready, noc_en_put, noc_put_flit[FW-1]} !== 3'b000) begin
            errors++;
            $display("FAIL tx_stall%0d: rdy/en/v got %b expected 000",
                     s, {tx_ready, noc_en_put, noc_put_flit[FW-1]});
          end
          tick();
        end
        noc_get_non_full_VCs = 2'b11;
      end
    end
    noc_get_non_full_VCs = 2'b10;
    tx_dest = 2'd2;
    tx_last = 1'b1;
    tx_data = 16'hBEEF;
    tx_q.push_back({1'b1, 1'b1, 2'd2, 1'b1, 16'hBEEF});
    #1;
    exp = tx_q.pop_front();
    checks++;
    if (noc_en_put !== 1'b1 || noc_put_flit !== exp) begin
      errors++;
      $display("FAIL tx_vc1_select: got en=%b flit=%h expected en=1 flit=%h",
               noc_en_put, noc_put_flit, exp);
    end
    tick();
    noc_get_non_full_VCs = 2'b00;
    #1;
    checks++;
    if ({tx_ready, noc_en_put} !== 2'b00) begin
      errors++;
      $display("FAIL tx_no_space: rdy/en got %b expected 00",
               {tx_ready, noc_en_put});
    end
    tx_valid = 1'b0;
    tick();
  endtask

  task automatic test_rx_overflow();
    logic [17:0] exp;
    int pops;
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      noc_get_flit = {1'b1, 1'b1, 2'd1, 1'b1, 16'(16'h0100 + i)};
      if (i < 4) rx_q.push_back({1'b1, 1'b1, 16'(16'h0100 + i)});
      tick();
      if (i == 0) begin
        checks++;
        if (rx_valid !== 1'b1) begin
          errors++;
          $display("FAIL rx_latency: rx_valid got %b expected 1", rx_valid);
        end
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (noc_put_non_full_VCs[1] !== (i == 1)) begin
          errors++;
          $display("FAIL rx_nf_after%0d: got %b expected %b",
                   i + 1, noc_put_non_full_VCs[1], (i == 1));
        end
      end
      if (i >= 3) begin
        checks++;
        if (rx_overflow !== (i == 4)) begin
          errors++;
          $display("FAIL rx_overflow_after%0d: got %b expected %b",
                   i + 1, rx_overflow, (i == 4));
        end
      end
    end
    noc_get_flit = '0;
    rx_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      if (rx_valid) begin
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_drain_extra: got %h expected none",
                   {rx_vc, rx_last, rx_data});
        end else begin
          exp = rx_q.pop_front();
          pops++;
          if ({rx_vc, rx_last, rx_data} !== exp) begin
            errors++;
            $display("FAIL rx_drain%0d: got %h expected %h",
                     pops, {rx_vc, rx_last, rx_data}, exp);
          end
        end
      end
      tick();
    end
    checks++;
    if (pops != 4 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rx_drain_count: got %0d expected 4", pops);
      rx_q.delete();
    end
    checks++;
    if (noc_put_non_full_VCs !== 2'b11) begin
      errors++;
      $display("FAIL rx_nf_recover: got %b expected 11",
               noc_put_non_full_VCs);
    end
  endtask

  task automatic test_rx_interleave();
    logic [FW-1:0] st [4];
    logic [17:0] exp;
    int pops;
    st[0] = {1'b1, 1'b0, 2'd1, 1'b0, 16'hA000};
    st[1] = {1'b1, 1'b0, 2'd1, 1'b1, 16'hB000};
    st[2] = {1'b1, 1'b1, 2'd1, 1'b0, 16'hA001};
    st[3] = {1'b1, 1'b1, 2'd1, 1'b1, 16'hB001};
    rx_q.push_back({1'b0, 1'b0, 16'hA000});
    rx_q.push_back({1'b0, 1'b1, 16'hA001});
    rx_q.push_back({1'b1, 1'b0, 16'hB000});
    rx_q.push_back({1'b1, 1'b1, 16'hB001});
    rx_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      noc_get_flit = (c < 4) ? st[c] : '0;
      if (rx_valid) begin
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_il_extra: got %h expected none",
                   {rx_vc, rx_last, rx_data});
        end else begin
          exp = rx_q.pop_front();
          pops++;
          if ({rx_vc, rx_last, rx_data} !== exp) begin
            errors++;
            $display("FAIL rx_il%0d: got %h expected %h",
                     pops, {rx_vc, rx_last, rx_data}, exp);
          end
        end
      end
      tick();
    end
    checks++;
    if (pops != 4 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rx_il_count: got %0d expected 4", pops);
      rx_q.delete();
    end
  endtask

  task automatic test_dest_check();
    logic [17:0] exp;
    int pops;
    noc_this_id = 2'd1;
    rx_ready = 1'b1;
`ifndef NOC_NI_DEST_CHECK_EN
    rx_q.push_back({1'b0, 1'b1, 16'hD00D});
`endif
    noc_get_flit = {1'b1, 1'b1, 2'd2, 1'b0, 16'hD00D};
    tick();
    noc_get_flit = '0;
    pops = 0;
    for (int c = 0; c < 4; c++) begin
      if (rx_valid) begin
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL dest_delivered: got %h expected none",
                   {rx_vc, rx_last, rx_data});
        end else begin
          exp = rx_q.pop_front();
          pops++;
          if ({rx_vc, rx_last, rx_data} !== exp) begin
            errors++;
            $display("FAIL dest_word: got %h expected %h",
                     {rx_vc, rx_last, rx_data}, exp);
          end
        end
      end
      tick();
    end
    checks++;
`ifdef NOC_NI_DEST_CHECK_EN
    if (err_dest !== 1'b1 || pops != 0) begin
      errors++;
      $display("FAIL dest_check: err=%b pops=%0d expected err=1 pops=0",
               err_dest, pops);
    end
`else
    if (err_dest !== 1'b0 || pops != 1) begin
      errors++;
      $display("FAIL dest_nocheck: err=%b pops=%0d expected err=0 pops=1",
               err_dest, pops);
    end
`endif
    rx_q.delete();
  endtask

  task automatic test_reset_mid_packet();
    noc_get_non_full_VCs = 2'b11;
    tx_valid = 1'b1;
    tx_last  = 1'b0;
    tx_dest  = 2'd1;
    tx_data  = 16'h0005;
    tick();
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      noc_get_flit = {1'b1, 1'b0, 2'd1, 1'b0, 16'(16'h0E00 + i)};
      tick();
    end
    noc_get_flit = '0;
    res = 1'b1;
    tick();
    res = 1'b0;
    tick();
    checks++;
    if ({rx_valid, rx_overflow} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_rx: valid/ovf got %b expected 00",
               {rx_valid, rx_overflow});
    end
    noc_get_non_full_VCs = 2'b10;
    tx_valid = 1'b1;
    tx_last  = 1'b1;
    tx_dest  = 2'd2;
    tx_data  = 16'h0007;
    tx_q.push_back({1'b1, 1'b1, 2'd2, 1'b1, 16'h0007});
    #1;
    checks++;
    if (noc_en_put !== 1'b1 || noc_put_flit !== tx_q[0]) begin
      errors++;
      $display("FAIL mid_reset_tx_idle: got en=%b flit=%h expected en=1 flit=%h",
               noc_en_put, noc_put_flit, tx_q[0]);
    end
    void'(tx_q.pop_front());
    tick();
    tx_valid = 1'b0;
    tick();
  endtask

  initial begin
    res = 1'b1;
    noc_get_non_full_VCs = 2'b00;
    noc_get_flit = '0;
    noc_this_id = 2'd1;
    tx_valid = 1'b0;
    tx_dest = '0;
    tx_last = 1'b0;
    tx_data = '0;
    rx_ready = 1'b0;
    test_reset();
    test_tx_packet();
    test_rx_overflow();
    test_rx_interleave();
    test_dest_check();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
